// File: rtl/cordic_arb_defs_pkg.sv
// Shared definitions for the CORDIC phase arbiter: FSM state encoding and
// default handshake/watchdog limits.
package cordic_arb_defs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    ACK_WAIT = 2'd2,
    RUN      = 2'd3
  } arb_state_e;

  localparam int ACK_MAX_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 1023;
  localparam int WD_W            = 10;

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: first set valid searching upward from
// rr_ptr+1, wrapping modulo NUM_CH.
module cordic_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any_valid
);

  int c;

  always_comb begin
    grant     = '0;
    idx       = '0;
    c         = 0;
    any_valid = |valid;
    // Walk farthest-first so the nearest candidate after rr_ptr overwrites last.
    for (int k = NUM_CH; k >= 1; k--) begin
      c = (int'(rr_ptr) + k) % NUM_CH;
      if (valid[c[CH_W-1:0]]) begin
        grant                = '0;
        grant[c[CH_W-1:0]]   = 1'b1;
        idx                  = c[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cordic_phase_arbiter.sv
// Round-robin scheduler sharing one CORDIC phase engine among NUM_CH requesters.
// Optional RUN-state watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_phase_arbiter
  import cordic_arb_defs::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 24,
  parameter int CH_W    = 2,
  parameter int ACK_MAX = ACK_MAX_DEF
`ifdef CORDIC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic [NUM_CH-1:0]        iReq_valid,
  input  logic [NUM_CH*DATA_W-1:0] iReq_data,
  output logic [NUM_CH-1:0]        oReq_ready,
  output logic                     oCore_data_valid,
  output logic [DATA_W-1:0]        oCore_data,
  input  logic                     iCore_ready,
  output logic                     oTag_valid,
  output logic [CH_W-1:0]          oTag,
  output logic                     oBusy,
  output logic                     oTimeout
);

  localparam int ACK_W = $clog2(ACK_MAX + 1);

  arb_state_e                      state;
  logic [CH_W-1:0]                 rr_ptr, tag_q, pick_idx;
  logic [DATA_W-1:0]               data_q;
  logic [ACK_W-1:0]                ack_cnt;
  logic                            issue_q;
  logic [NUM_CH-1:0]               pick_grant;
  logic                            any_valid, grant;
  logic [NUM_CH-1:0][DATA_W-1:0]   req_words;

  assign req_words = iReq_data;

  cordic_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .valid     (iReq_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  assign grant      = (state == IDLE) && iCore_ready && any_valid;
  // Strobe is masked during reset so every output reads 0 while held.
  assign oReq_ready = (iReset_n && state == IDLE && iCore_ready) ? pick_grant : '0;

  assign oCore_data_valid = issue_q;
  assign oTag_valid       = issue_q;
  assign oCore_data       = data_q;
  assign oTag             = tag_q;
  assign oBusy            = (state != IDLE);

`ifdef CORDIC_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state   <= IDLE;
      rr_ptr  <= CH_W'(NUM_CH - 1);
      data_q  <= '0;
      tag_q   <= '0;
      ack_cnt <= '0;
      issue_q <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      issue_q <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant) begin
            data_q  <= req_words[pick_idx];
            tag_q   <= pick_idx;
            rr_ptr  <= pick_idx;
            issue_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          ack_cnt <= '0;
          state   <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (!iCore_ready) begin
            state <= RUN;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            // Engine never dropped ready: treat as a zero-rotation completion.
            ack_cnt <= ack_cnt + 1'b1;
            if (ack_cnt == ACK_W'(ACK_MAX - 1)) state <= IDLE;
          end
        end
        RUN: begin
          if (iCore_ready) begin
            state <= IDLE;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_arbiter.sv
// Self-checking bench for cordic_phase_arbiter: directed scenarios plus
// randomized phases against a transaction-level round-robin model.
module tb_cordic_phase_arbiter;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic [3:0]  iReq_valid;
  logic [95:0] iReq_data;
  logic [3:0]  oReq_ready;
  logic        oCore_data_valid;
  logic [23:0] oCore_data;
  logic        iCore_ready;
  logic        oTag_valid;
  logic [1:0]  oTag;
  logic        oBusy;
  logic        oTimeout;

  int errors = 0;
  int checks = 0;
  int mptr;

  cordic_phase_arbiter dut (
    .iClk             (iClk),
    .iReset_n         (iReset_n),
    .iReq_valid       (iReq_valid),
    .iReq_data        (iReq_data),
    .oReq_ready       (oReq_ready),
    .oCore_data_valid (oCore_data_valid),
    .oCore_data       (oCore_data),
    .iCore_ready      (iCore_ready),
    .oTag_valid       (oTag_valid),
    .oTag             (oTag),
    .oBusy            (oBusy),
    .oTimeout         (oTimeout)
  );

  always #5 iClk = ~iClk;

  // Reference: first requesting channel strictly after the last winner, wrapping.
  function automatic int model_pick(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Busy cycles from the issue cycle to the return to IDLE, engine ready
  // held low for run_len cycles starting right after the issue.
  function automatic int exp_busy(input int run_len);
    if (run_len == 0) return 1 + 4;
`ifdef CORDIC_ARB_TIMEOUT_EN
    if (run_len > 1023) return 2 + 1023;
`endif
    return run_len + 2;
  endfunction

  function automatic logic [95:0] rand_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drives one request/issue/engine cycle and reports what the DUT did.
  task automatic do_phase(input logic [3:0] vmask, input logic [95:0] dat, input int run_len,
                          output logic [3:0] gnt, output logic iv, output logic tv,
                          output logic [1:0] tag, output logic [23:0] od,
                          output int busy, output int to_cnt);
    iReq_valid = vmask; iReq_data = dat; iCore_ready = 1'b1;
    #1 gnt = oReq_ready;
    @(posedge iClk); #1 iReq_valid = '0;
    @(negedge iClk);
    iv = oCore_data_valid; tv = oTag_valid; tag = oTag; od = oCore_data;
    busy = oBusy ? 1 : 0;
    to_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge iClk); #1 iCore_ready = (k < run_len) ? 1'b0 : 1'b1;
      @(negedge iClk);
      if (oTimeout) to_cnt++;
      if (!oBusy) break;
      busy++;
    end
  endtask

  // Full check of one granted phase against the model.
  task automatic test_phase_model(input string nm, input logic [3:0] vmask, input int run_len);
    logic [3:0] gnt; logic iv, tv; logic [1:0] tag; logic [23:0] od; int busy, to_cnt, w;
    logic [95:0] dat; logic [3:0] eg;
    dat = rand_data();
    w = model_pick(vmask, mptr);
    eg = 4'b0001 << w;
    do_phase(vmask, dat, run_len, gnt, iv, tv, tag, od, busy, to_cnt);
    checks++; if (gnt !== eg) begin errors++; $display("FAIL %s.grant: got %b want %b", nm, gnt, eg); end
    checks++; if ({iv, tv} !== 2'b11) begin errors++; $display("FAIL %s.valid: got %b want 11", nm, {iv, tv}); end
    checks++; if (tag !== 2'(w)) begin errors++; $display("FAIL %s.tag: got %0d want %0d", nm, tag, w); end
    checks++; if (od !== dat[w*24 +: 24]) begin errors++; $display("FAIL %s.data: got %h want %h", nm, od, dat[w*24 +: 24]); end
    checks++; if (busy != exp_busy(run_len)) begin errors++; $display("FAIL %s.busy: got %0d want %0d", nm, busy, exp_busy(run_len)); end
    mptr = w;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iReq_valid = 4'hF; iReq_data = rand_data(); iCore_ready = 1'b1;
    repeat (3) @(negedge iClk);
    checks++; if (oReq_ready !== 4'b0) begin errors++; $display("FAIL reset.req_ready: got %b want 0000", oReq_ready); end
    checks++; if ({oCore_data_valid, oTag_valid, oBusy, oTimeout} !== 4'b0) begin
      errors++; $display("FAIL reset.flags: got %b want 0000", {oCore_data_valid, oTag_valid, oBusy, oTimeout}); end
    checks++; if ({oCore_data, oTag} !== 26'b0) begin errors++; $display("FAIL reset.regs: got %h want 0", {oCore_data, oTag}); end
    iReq_valid = '0;
    iReset_n = 1'b1;
    mptr = 3;
    @(posedge iClk); #1;
    @(negedge iClk);
    checks++; if ({oBusy, oReq_ready} !== 5'b0) begin errors++; $display("FAIL reset.idle: got %b want 00000", {oBusy, oReq_ready}); end
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < 5; i++) test_phase_model("all_valid", 4'hF, 8);
  endtask

  task automatic test_single();
    logic [3:0] gnt; logic iv, tv; logic [1:0] tag; logic [23:0] od; int busy, to_cnt;
    logic [95:0] dat;
    dat = rand_data();
    dat[2*24 +: 24] = 24'h123456;
    do_phase(4'b0100, dat, 10, gnt, iv, tv, tag, od, busy, to_cnt);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single.grant: got %b want 0100", gnt); end
    checks++; if ({iv, tv, tag} !== 4'b1110) begin errors++; $display("FAIL single.issue: got %b want 1110", {iv, tv, tag}); end
    checks++; if (od !== 24'h123456) begin errors++; $display("FAIL single.data: got %h want 123456", od); end
    checks++; if (busy != 12) begin errors++; $display("FAIL single.busy: got %0d want 12", busy); end
    mptr = 2;
  endtask

  task automatic test_no_ack();
    test_phase_model("no_ack", 4'hF, 0);
    test_phase_model("no_ack", 4'hF, 0);
  endtask

  task automatic test_ready_block();
    iReq_valid = 4'hF; iReq_data = rand_data(); iCore_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      checks++; if ({oReq_ready, oCore_data_valid, oBusy} !== 6'b0) begin
        errors++; $display("FAIL ready_block.cycle%0d: got %b want 000000", i, {oReq_ready, oCore_data_valid, oBusy}); end
    end
    test_phase_model("ready_resume", 4'hF, 3);
  endtask

  task automatic test_random();
    int rl;
    for (int i = 0; i < 30; i++) begin
      rl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      test_phase_model("random", 4'($urandom_range(1, 15)), rl);
    end
  endtask

  task automatic test_reset_mid_run();
    iReq_valid = 4'b1000; iReq_data = rand_data(); iCore_ready = 1'b1;
    @(posedge iClk); #1 iReq_valid = '0;
    @(posedge iClk); #1 iCore_ready = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checks++; if ({oBusy, oTag} !== 3'b111) begin errors++; $display("FAIL mid_run.inflight: got %b want 111", {oBusy, oTag}); end
    #2 iReset_n = 1'b0; iReq_valid = 4'hF; iCore_ready = 1'b1;
    #1;
    checks++; if ({oReq_ready, oCore_data_valid, oTag_valid, oBusy, oTag} !== 9'b0) begin
      errors++; $display("FAIL mid_run.reset_outs: got %b want 0", {oReq_ready, oCore_data_valid, oTag_valid, oBusy, oTag}); end
    iCore_ready = 1'b0;
    @(posedge iClk); #1 iReset_n = 1'b1;
    mptr = 3;
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      checks++; if (oReq_ready !== 4'b0) begin errors++; $display("FAIL mid_run.no_ready: got %b want 0000", oReq_ready); end
    end
    test_phase_model("mid_run_resume", 4'hF, 2);
  endtask

  task automatic test_timeout();
    logic [3:0] gnt; logic iv, tv; logic [1:0] tag; logic [23:0] od; int busy, to_cnt, w, exp_to;
`ifdef CORDIC_ARB_TIMEOUT_EN
    exp_to = 1;
`else
    exp_to = 0;
`endif
    w = model_pick(4'b0010, mptr);
    do_phase(4'b0010, rand_data(), 1100, gnt, iv, tv, tag, od, busy, to_cnt);
    checks++; if (busy != exp_busy(1100)) begin errors++; $display("FAIL timeout.busy: got %0d want %0d", busy, exp_busy(1100)); end
    checks++; if (to_cnt != exp_to) begin errors++; $display("FAIL timeout.pulse: got %0d want %0d", to_cnt, exp_to); end
    @(negedge iClk);
    checks++; if (oTimeout !== 1'b0) begin errors++; $display("FAIL timeout.one_cycle: got %b want 0", oTimeout); end
    mptr = w;
    test_phase_model("timeout_next", 4'hF, 1);
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_single();
    test_no_ack();
    test_ready_block();
    test_random();
    test_reset_mid_run();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
